k052109_vram_sched: RTL and testbench

K052109_VRAM_SCHED -- requirements
Module: k052109_vram_sched

---
 rtl/k052109_pkg.sv | 44 ++++
 rtl/k052109_vram_sched_if.sv | 23 ++
 rtl/k052109_slot_ctr.sv | 33 +++
 rtl/k052109_vram_sched.sv | 132 +++++++++++++
 tb/tb_k052109_vram_sched.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/k052109_pkg.sv
// Shared definitions for the K052109 VRAM slot scheduler: slot indices,
// owner states and LATCH strobe bit positions.
package k052109_pkg;

  typedef logic [2:0] slot_t;

  localparam slot_t SLOT_A     = 3'd0;
  localparam slot_t SLOT_B     = 3'd1;
  localparam slot_t SLOT_FIX   = 3'd2;
  localparam slot_t SLOT_SCR   = 3'd3;
  localparam slot_t SLOT_RESET = 3'd7;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_CPU_RD,
    OWN_CPU_WR
  } owner_e;

  localparam int LAT_A   = 0;
  localparam int LAT_B   = 1;
  localparam int LAT_FIX = 2;
  localparam int LAT_SCR = 3;

  // Slot 3 only becomes a scroll fetch while scroll fetching is enabled.
  function automatic logic is_fetch_slot(slot_t s, logic sc_en);
    return (s == SLOT_A) || (s == SLOT_B) || (s == SLOT_FIX) ||
           ((s == SLOT_SCR) && sc_en);
  endfunction

  function automatic logic [3:0] latch_bit(slot_t s);
    logic [3:0] l;
    l = '0;
    case (s)
      SLOT_A:   l[LAT_A]   = 1'b1;
      SLOT_B:   l[LAT_B]   = 1'b1;
      SLOT_FIX: l[LAT_FIX] = 1'b1;
      SLOT_SCR: l[LAT_SCR] = 1'b1;
      default:  l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/k052109_vram_sched_if.sv
// CPU request/acknowledge handshake plus the VRAM pin bundle driven by the scheduler.
interface k052109_vram_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic [12:0] cpu_addr;
  logic [1:0]  cpu_bsel;
  logic        cpu_ack;
  logic        cpu_rdv;
  logic [12:0] ra;
  logic [1:0]  rcs;
  logic        roe;
  logic        rwe;

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_bsel,
    input  cpu_ack, cpu_rdv, ra, rcs, roe, rwe
  );

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_bsel,
    output cpu_ack, cpu_rdv, ra, rcs, roe, rwe
  );
endinterface

// File: rtl/k052109_slot_ctr.sv
// Eight-slot counter advanced by the pixel enable, with a pending realign
// that forces the following slot back to index 0.
module k052109_slot_ctr
  import k052109_pkg::*;
(
  input  logic  m24,
  input  logic  res,
  input  logic  px_ce,
  input  logic  line_start,
  output slot_t slot,
  output slot_t slot_next
);

  logic realign;

  always_comb slot_next = realign ? SLOT_A : slot + 3'd1;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge m24 or negedge res) begin
    if (!res) begin
      slot    <= SLOT_RESET;
      realign <= 1'b0;
    end else if (px_ce) begin
      slot    <= slot_next;
      // A line start coinciding with the boundary applies to the next boundary.
      realign <= line_start;
    end else if (line_start) begin
      realign <= 1'b1;
    end
  end

endmodule

// File: rtl/k052109_vram_sched.sv
// VRAM slot scheduler: decides the owner of each pixel slot, drives the VRAM
// pins at slot start and issues capture strobes / CPU acknowledges at slot end.
module k052109_vram_sched
  import k052109_pkg::*;
(
  input  logic        m24,
  input  logic        res,
  input  logic        px_ce,
  input  logic        line_start,
  input  logic        sc_en,
  input  logic [12:0] tf_addr_a,
  input  logic [12:0] tf_addr_b,
  input  logic [12:0] tf_addr_f,
  input  logic [12:0] sc_addr,
  k052109_vram_if.slave bus,
  output logic [3:0]  latch
);

  slot_t       slot;
  slot_t       slot_next;
  owner_e      owner;
  owner_e      owner_next;
  logic [12:0] fetch_addr;
  logic        first_cyc;

  logic [12:0] ra_q, ra_d;
  logic [1:0]  rcs_q, rcs_d;
  logic        roe_q, roe_d;
  logic        rwe_q, rwe_d;
  logic        ack_q, ack_d;
  logic        rdv_q, rdv_d;
  logic [3:0]  latch_q, latch_d;

  k052109_slot_ctr u_slot_ctr (
    .m24        (m24),
    .res        (res),
    .px_ce      (px_ce),
    .line_start (line_start),
    .slot       (slot),
    .slot_next  (slot_next)
  );

  always_comb begin
    unique case (slot_next)
      SLOT_A:   fetch_addr = tf_addr_a;
      SLOT_B:   fetch_addr = tf_addr_b;
      SLOT_FIX: fetch_addr = tf_addr_f;
      default:  fetch_addr = sc_addr;
    endcase
  end

  always_ff @(posedge m24 or negedge res) begin
    if (!res) owner <= OWN_NONE;
    else      owner <= owner_next;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    owner_next = owner;
    if (px_ce) begin
      if (is_fetch_slot(slot_next, sc_en)) owner_next = OWN_FETCH;
      else if (bus.cpu_req)                owner_next = bus.cpu_wr ? OWN_CPU_WR : OWN_CPU_RD;
      else                                 owner_next = OWN_NONE;
    end
  end

  always_comb begin
    ra_d  = ra_q;
    rcs_d = rcs_q;
    roe_d = roe_q;
    if (px_ce) begin
      case (owner_next)
        OWN_FETCH: begin
          ra_d  = fetch_addr;
          rcs_d = 2'b00;
          roe_d = 1'b0;
        end
        OWN_CPU_RD: begin
          ra_d  = bus.cpu_addr;
          rcs_d = ~bus.cpu_bsel;
          roe_d = 1'b0;
        end
        OWN_CPU_WR: begin
          ra_d  = bus.cpu_addr;
          rcs_d = ~bus.cpu_bsel;
          roe_d = 1'b1;
        end
        default: begin
          rcs_d = 2'b11;
          roe_d = 1'b1;
        end
      endcase
    end
    // Write strobe covers only the second cycle of a write slot.
    rwe_d   = !((owner == OWN_CPU_WR) && first_cyc && !px_ce);
    latch_d = (px_ce && (owner == OWN_FETCH)) ? latch_bit(slot) : 4'b0000;
    ack_d   = px_ce && ((owner == OWN_CPU_RD) || (owner == OWN_CPU_WR));
    rdv_d   = px_ce && (owner == OWN_CPU_RD);
  end

  always_ff @(posedge m24 or negedge res) begin
    if (!res) begin
      ra_q      <= '0;
      rcs_q     <= 2'b11;
      roe_q     <= 1'b1;
      rwe_q     <= 1'b1;
      ack_q     <= 1'b0;
      rdv_q     <= 1'b0;
      latch_q   <= 4'b0000;
      first_cyc <= 1'b0;
    end else begin
      ra_q      <= ra_d;
      rcs_q     <= rcs_d;
      roe_q     <= roe_d;
      rwe_q     <= rwe_d;
      ack_q     <= ack_d;
      rdv_q     <= rdv_d;
      latch_q   <= latch_d;
      first_cyc <= px_ce;
    end
  end

  assign bus.ra      = ra_q;
  assign bus.rcs     = rcs_q;
  assign bus.roe     = roe_q;
  assign bus.rwe     = rwe_q;
  assign bus.cpu_ack = ack_q;
  assign bus.cpu_rdv = rdv_q;
  assign latch       = latch_q;

endmodule

// File: tb/tb_k052109_vram_sched.sv
// Randomised scoreboard bench for the VRAM slot scheduler with a slot-level reference model.
module tb_k052109_vram_sched;

  logic        m24 = 1'b0;
  logic        res = 1'b1;
  logic        px_ce = 1'b0;
  logic        line_start = 1'b0;
  logic        sc_en = 1'b0;
  logic [12:0] tf_addr_a = 13'h0101;
  logic [12:0] tf_addr_b = 13'h0202;
  logic [12:0] tf_addr_f = 13'h0303;
  logic [12:0] sc_addr   = 13'h0404;
  logic [3:0]  latch;

  k052109_vram_if bus ();

  k052109_vram_sched dut (
    .m24        (m24),
    .res        (res),
    .px_ce      (px_ce),
    .line_start (line_start),
    .sc_en      (sc_en),
    .tf_addr_a  (tf_addr_a),
    .tf_addr_b  (tf_addr_b),
    .tf_addr_f  (tf_addr_f),
    .sc_addr    (sc_addr),
    .bus        (bus),
    .latch      (latch)
  );

  always #5 m24 = ~m24;

  localparam int K_NONE  = 0;
  localparam int K_FETCH = 1;
  localparam int K_RD    = 2;
  localparam int K_WR    = 3;

  typedef struct {
    int          due;
    logic [12:0] ra;
    logic [1:0]  rcs;
    logic        roe;
  } bus_exp_t;

  typedef struct {
    int         due;
    logic [3:0] latch;
    logic       ack;
    logic       rdv;
  } evt_exp_t;

  bus_exp_t bus_q[$];
  evt_exp_t evt_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Reference model of the slot sequence
  int          m_slot = 7;
  int          m_kind = K_NONE;
  logic [12:0] m_ra = 13'h0;
  bit          m_pend = 1'b0;
  int          m_cyc_in_slot = 0;

  // Stimulus knobs
  int since_px = 0;
  int gap      = 4;
  int min_gap  = 4;
  int max_gap  = 4;
  bit rnd_cpu  = 1'b0;
  bit rnd_misc = 1'b0;
  bit ls_shot  = 1'b0;
  bit drop_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic raise(input logic wr, input logic [12:0] addr, input logic [1:0] bsel);
    bus.cpu_req  = 1'b1;
    bus.cpu_wr   = wr;
    bus.cpu_addr = addr;
    bus.cpu_bsel = bsel;
  endtask

  // Applies the slot rules at a clock edge using the inputs presented to it.
  task automatic model_edge();
    int         nxt;
    logic [1:0] rcs;
    logic       roe;
    if (px_ce) begin
      if (m_kind == K_FETCH)
        evt_q.push_back('{due: cyc + 1, latch: 4'(1 << m_slot), ack: 1'b0, rdv: 1'b0});
      else if (m_kind != K_NONE)
        evt_q.push_back('{due: cyc + 1, latch: 4'b0000, ack: 1'b1, rdv: (m_kind == K_RD)});
      nxt    = m_pend ? 0 : (m_slot + 1) % 8;
      m_pend = line_start;
      m_slot = nxt;
      if (nxt <= 2 || (nxt == 3 && sc_en)) begin
        m_kind = K_FETCH;
        rcs    = 2'b00;
        roe    = 1'b0;
        case (nxt)
          0:       m_ra = tf_addr_a;
          1:       m_ra = tf_addr_b;
          2:       m_ra = tf_addr_f;
          default: m_ra = sc_addr;
        endcase
      end else if (bus.cpu_req) begin
        m_kind = bus.cpu_wr ? K_WR : K_RD;
        m_ra   = bus.cpu_addr;
        rcs    = ~bus.cpu_bsel;
        roe    = bus.cpu_wr;
      end else begin
        m_kind = K_NONE;
        rcs    = 2'b11;
        roe    = 1'b1;
      end
      bus_q.push_back('{due: cyc + 1, ra: m_ra, rcs: rcs, roe: roe});
      m_cyc_in_slot = 0;
    end else if (line_start) begin
      m_pend = 1'b1;
    end
  endtask

  // One M24 cycle: requester, pixel enable and misc inputs, then the edge.
  task automatic cycle();
    if (drop_next) begin
      bus.cpu_req = 1'b0;
      drop_next   = 1'b0;
    end else if (bus.cpu_req && bus.cpu_ack) begin
      drop_next = 1'b1;
    end else if (!bus.cpu_req && rnd_cpu && $urandom_range(0, 3) == 0) begin
      raise(1'($urandom_range(0, 1)), 13'($urandom), 2'($urandom_range(0, 3)));
    end
    px_ce = (since_px >= gap);
    if (px_ce) begin
      since_px = 0;
      gap      = $urandom_range(min_gap, max_gap);
    end
    line_start = 1'b0;
    if (ls_shot && !px_ce) begin
      line_start = 1'b1;
      ls_shot    = 1'b0;
    end else if (rnd_misc && $urandom_range(0, 59) == 0) begin
      line_start = 1'b1;
    end
    if (rnd_misc) begin
      if ($urandom_range(0, 49) == 0) sc_en = ~sc_en;
      tf_addr_a = 13'($urandom);
      tf_addr_b = 13'($urandom);
      tf_addr_f = 13'($urandom);
      sc_addr   = 13'($urandom);
    end
    @(posedge m24);
    model_edge();
    #1;
    cyc++;
    since_px++;
    m_cyc_in_slot++;
  endtask

  task automatic wait_slot(input int slot, input string name);
    for (int i = 0; i < 100 && !(m_slot == slot && m_cyc_in_slot == 1); i++) cycle();
    check(name, m_slot, slot);
  endtask

  // Monitor: compares DUT outputs against queued expectations away from the edge.
  initial begin
    forever begin
      @(negedge m24);
      if (mon_en) begin
        check("rwe", bus.rwe, !(m_kind == K_WR && m_cyc_in_slot == 2));
        if (bus_q.size() > 0 && bus_q[0].due == cyc) begin
          bus_exp_t b;
          b = bus_q.pop_front();
          check("ra", bus.ra, b.ra);
          check("rcs", bus.rcs, b.rcs);
          check("roe", bus.roe, b.roe);
        end
        if (evt_q.size() > 0 && evt_q[0].due == cyc) begin
          evt_exp_t e;
          e = evt_q.pop_front();
          check("latch", latch, e.latch);
          check("cpu_ack", bus.cpu_ack, e.ack);
          check("cpu_rdv", bus.cpu_rdv, e.rdv);
        end else if (latch != 4'b0000 || bus.cpu_ack || bus.cpu_rdv) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected strobe: latch=%b ack=%b rdv=%b, none due at cycle %0d",
                   latch, bus.cpu_ack, bus.cpu_rdv, cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.cpu_req  = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_bsel = '0;

    // Reset values
    #2 res = 1'b0;
    #1;
    check("reset ra", bus.ra, 13'h0);
    check("reset rcs", bus.rcs, 2'b11);
    check("reset roe", bus.roe, 1'b1);
    check("reset rwe", bus.rwe, 1'b1);
    check("reset ack", bus.cpu_ack, 1'b0);
    check("reset rdv", bus.cpu_rdv, 1'b0);
    check("reset latch", latch, 4'b0000);
    repeat (3) @(posedge m24);
    #1 res = 1'b1;
    mon_en = 1'b1;

    // Fetch-only line, PX_CE every 4 cycles
    repeat (72) cycle();

    // Directed write requested at slot 0 with scroll fetch enabled
    sc_en = 1'b1;
    wait_slot(0, "reach slot 0 for write");
    raise(1'b1, 13'h1A5A, 2'b10);
    repeat (40) cycle();

    // Read requested during a scroll-fetch slot 3
    wait_slot(3, "reach slot 3 for read");
    raise(1'b0, 13'h0777, 2'b11);
    repeat (40) cycle();

    // Line start during slot 5 while a read is in progress
    for (int i = 0; i < 100 && (bus.cpu_req || drop_next); i++) cycle();
    wait_slot(4, "reach slot 4 for realign");
    raise(1'b0, 13'h0555, 2'b01);
    wait_slot(5, "reach slot 5 for realign");
    check("slot 5 owned by read", m_kind, K_RD);
    ls_shot = 1'b1;
    repeat (40) cycle();

    // Zero lane select still acknowledged
    for (int i = 0; i < 100 && (bus.cpu_req || drop_next); i++) cycle();
    raise(1'b0, 13'h0123, 2'b00);
    repeat (40) cycle();

    // Randomised traffic
    min_gap  = 2;
    max_gap  = 5;
    rnd_cpu  = 1'b1;
    rnd_misc = 1'b1;
    repeat (3000) cycle();

    // Reset during the strobe cycle of a write
    rnd_cpu  = 1'b0;
    rnd_misc = 1'b0;
    min_gap  = 4;
    max_gap  = 4;
    for (int i = 0; i < 100 && (bus.cpu_req || drop_next); i++) cycle();
    raise(1'b1, 13'h0ABC, 2'b11);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (m_kind == K_WR && m_cyc_in_slot == 2) begin
        found = 1'b1;
        break;
      end
    end
    check("write strobe cycle reached", found, 1'b1);
    check("rwe low before reset", bus.rwe, 1'b0);
    mon_en     = 1'b0;
    px_ce      = 1'b0;
    line_start = 1'b0;
    res        = 1'b0;
    #1;
    check("mid-write reset rwe", bus.rwe, 1'b1);
    check("mid-write reset rcs", bus.rcs, 2'b11);
    check("mid-write reset roe", bus.roe, 1'b1);
    check("mid-write reset ack", bus.cpu_ack, 1'b0);
    repeat (3) @(posedge m24);
    #1;
    check("ack held low in reset", bus.cpu_ack, 1'b0);
    bus.cpu_req = 1'b0;
    drop_next   = 1'b0;
    bus_q.delete();
    evt_q.delete();
    m_slot        = 7;
    m_kind        = K_NONE;
    m_ra          = 13'h0;
    m_pend        = 1'b0;
    m_cyc_in_slot = 0;
    since_px      = 0;
    gap           = 4;
    res           = 1'b1;
    mon_en        = 1'b1;
    repeat (48) cycle();

    repeat (2) @(posedge m24);
    check("bus expectations drained", bus_q.size(), 0);
    check("strobe expectations drained", evt_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
